// File: rtl/pp_ctrl_pkg.sv
// Shared definitions for the ping-pong bank controller: bank indices and the
// bit-reverse helper used when PP_CTRL_BITREV_EN is defined.
package pp_ctrl_pkg;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Reverses the low 'width' bits of addr; the caller truncates to its own width.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
    logic [31:0] r;
    int          j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        j    = width - 1 - i;
        r[j] = addr[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_addr_cnt.sv
// Bank address counter with increment, clear and terminal-count flag.
// Wraps naturally at 2**WIDTH, which equals the bank depth.
module pp_addr_cnt #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign wrap = &count;

endmodule

// File: rtl/pp_bank_ctrl.sv
// Two-bank ping-pong frame buffer sequencer: write/read pointers, full flags,
// bank swap and backpressure. PP_CTRL_BITREV_EN selects bit-reversed write addresses.
module pp_bank_ctrl
  import pp_ctrl_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  out_ready,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic                  frame_done
);

  logic                  wr_sel;
  logic                  rd_sel;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  wr_wrap;
  logic                  rd_wrap;
  logic                  wr_done;
  logic                  rd_done;
  logic [1:0]            full_next;

  assign in_ready = !bank_full[wr_sel];
  assign wr_en    = in_valid && in_ready;
  assign wr_bank  = wr_sel;
  assign rd_en    = bank_full[rd_sel] && (!out_valid || out_ready);
  assign rd_bank  = rd_sel;
  assign rd_addr  = rd_cnt;
  assign wr_done  = wr_en && wr_wrap;
  assign rd_done  = rd_en && rd_wrap;

`ifdef PP_CTRL_BITREV_EN
  assign wr_addr = ADDR_WIDTH'(bitrev(32'(wr_cnt), ADDR_WIDTH));
`else
  assign wr_addr = wr_cnt;
`endif

  pp_addr_cnt #(.WIDTH(ADDR_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .clear (wr_done),
    .count (wr_cnt),
    .wrap  (wr_wrap)
  );

  pp_addr_cnt #(.WIDTH(ADDR_WIDTH)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en),
    .clear (rd_done),
    .count (rd_cnt),
    .wrap  (rd_wrap)
  );

  // Writer only touches a non-full bank and reader only a full one, so both updates never collide.
  always_comb begin
    full_next = bank_full;
    if (wr_done) full_next[wr_sel] = 1'b1;
    if (rd_done) full_next[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel     <= BANK0;
      rd_sel     <= BANK0;
      bank_full  <= 2'b00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bank_full  <= full_next;
      frame_done <= rd_done;
      out_valid  <= rd_en || (out_valid && !out_ready);
      if (wr_done) wr_sel <= (wr_sel == BANK0) ? BANK1 : BANK0;
      if (rd_done) rd_sel <= (rd_sel == BANK0) ? BANK1 : BANK0;
      // out_last follows its beat and holds while the beat is stalled.
      if (rd_en) begin
        out_last <= rd_wrap;
      end else if (out_ready) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pp_bank_ctrl.sv
// Self-checking bench for pp_bank_ctrl (DEPTH=8): cycle model plus a write-to-read
// scoreboard, driven by a linear sequence of directed steps.
module tb_pp_bank_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_last;
  logic [1:0]    bank_full;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic bank;
    int   addr;
  } beat_t;

  beat_t      sb_q[$];
  logic       m_wr_sel = 1'b0;
  logic       m_rd_sel = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_ol = 1'b0;
  logic       m_fd = 1'b0;
  logic [1:0] m_full = 2'b00;
  int         m_wr_cnt = 0;

  int beats = 0;
  int lasts = 0;
  int fd_cnt = 0;
  int ir_low = 0;
  int ov_low = 0;

  pp_bank_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .out_ready  (out_ready),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .bank_full  (bank_full),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int tb_bitrev(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic int exp_wr_addr(input int cnt);
`ifdef PP_CTRL_BITREV_EN
    return tb_bitrev(cnt);
`else
    return cnt;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic r, input int n);
    in_valid  = v;
    out_ready = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_bank_full", 32'(bank_full), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_last", 32'(out_last), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_rd_en", 32'(rd_en), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_wr_bank", 32'(wr_bank), 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_rd_bank", 32'(rd_bank), 0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 0);
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    beats  = 0;
    lasts  = 0;
    fd_cnt = 0;
    ir_low = 0;
    ov_low = 0;
  endtask

  task automatic waitFrameDone(input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frame_done_wait", 32'(frame_done), 1);
  endtask

  // Cycle model sampled mid-cycle; state advances as if the next rising edge happened.
  always @(negedge clk) begin : monitor
    logic  exp_ir;
    logic  exp_rd;
    logic  wr_x;
    logic  rd_last;
    beat_t b;
    if (!rst_n) begin
      m_wr_sel = 1'b0;
      m_rd_sel = 1'b0;
      m_ov     = 1'b0;
      m_ol     = 1'b0;
      m_fd     = 1'b0;
      m_full   = 2'b00;
      m_wr_cnt = 0;
      sb_q.delete();
    end else begin
      exp_ir = !m_full[m_wr_sel];
      exp_rd = m_full[m_rd_sel] && (!m_ov || out_ready);
      wr_x   = in_valid && exp_ir;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ir));
      checkOutput("wr_en", 32'(wr_en), 32'(wr_x));
      checkOutput("bank_full", 32'(bank_full), 32'(m_full));
      checkOutput("rd_en", 32'(rd_en), 32'(exp_rd));
      checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
      checkOutput("out_last", 32'(out_last), 32'(m_ol));
      checkOutput("frame_done", 32'(frame_done), 32'(m_fd));
      if (out_valid && out_ready) beats++;
      if (out_valid && out_ready && out_last) lasts++;
      if (frame_done) fd_cnt++;
      if (!in_ready) ir_low++;
      if (!out_valid) ov_low++;
      if (wr_x) begin
        checkOutput("wr_bank", 32'(wr_bank), 32'(m_wr_sel));
        checkOutput("wr_addr", 32'(wr_addr), exp_wr_addr(m_wr_cnt));
        sb_q.push_back('{bank: m_wr_sel, addr: m_wr_cnt});
      end
      rd_last = 1'b0;
      if (exp_rd) begin
        checkOutput("sb_depth", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          b = sb_q.pop_front();
          checkOutput("rd_bank", 32'(rd_bank), 32'(b.bank));
          checkOutput("rd_addr", 32'(rd_addr), 32'(b.addr));
          rd_last = (b.addr == DEPTH - 1);
        end
      end
      m_ol = exp_rd ? rd_last : (out_ready ? 1'b0 : m_ol);
      m_ov = exp_rd || (m_ov && !out_ready);
      m_fd = exp_rd && rd_last;
      if (wr_x) begin
        if (m_wr_cnt == DEPTH - 1) begin
          m_full[m_wr_sel] = 1'b1;
          m_wr_sel = ~m_wr_sel;
          m_wr_cnt = 0;
        end else begin
          m_wr_cnt++;
        end
      end
      if (exp_rd && rd_last) begin
        m_full[m_rd_sel] = 1'b0;
        m_rd_sel = ~m_rd_sel;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int n;
    $display("[TB] start");

    // Single frame through bank 0 with the reader always ready.
    doReset();
    clearCounters();
    applyStimulus(1'b1, 1'b1, DEPTH);
    applyStimulus(1'b0, 1'b1, 14);
    checkOutput("t1_beats", 32'(beats), 8);
    checkOutput("t1_lasts", 32'(lasts), 1);
    checkOutput("t1_frame_done", 32'(fd_cnt), 1);
    checkOutput("t1_bank_full", 32'(bank_full), 0);

    // Both banks full, 17th sample held until bank 0 drains.
    doReset();
    applyStimulus(1'b1, 1'b0, 2 * DEPTH);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("t2_bank_full", 32'(bank_full), 3);
    checkOutput("t2_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    waitFrameDone(30);
    checkOutput("t2_in_ready_after", 32'(in_ready), 1);
    checkOutput("t2_wr_bank", 32'(wr_bank), 0);
    checkOutput("t2_wr_addr", 32'(wr_addr), 0);

    // Steady streaming: no backpressure and no output bubbles across swaps.
    clearCounters();
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("t3_in_ready_low", 32'(ir_low), 0);
    checkOutput("t3_out_valid_low", 32'(ov_low), 0);
    checkOutput("t3_frames", 32'(fd_cnt), 5);

    // Drain everything, then fill exactly one fresh frame with the reader stalled.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((bank_full != 2'b00 || out_valid) && n < 40);
    checkOutput("t4_drained", 32'(bank_full), 0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bank_full == 2'b00 && n < 20);
    in_valid = 1'b0;
    checkOutput("t4_fill", 32'(bank_full != 2'b00), 1);
    clearCounters();
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    checkOutput("t4_beats", 32'(beats), 8);
    checkOutput("t4_lasts", 32'(lasts), 1);
    checkOutput("t4_frame_done", 32'(fd_cnt), 1);
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 4);

    // Reset in the middle of a drain with a partial frame pending.
    applyStimulus(1'b1, 1'b1, DEPTH + 5);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkResetState();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clearCounters();
    in_valid = 1'b1;
    #1;
    checkOutput("t5_wr_en", 32'(wr_en), 1);
    checkOutput("t5_wr_bank", 32'(wr_bank), 0);
    checkOutput("t5_wr_addr", 32'(wr_addr), 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 12);
    checkOutput("t5_stale_beats", 32'(beats), 0);
    checkOutput("t5_frame_done", 32'(fd_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
